// File: rtl/hbm_axi_burst_master.sv
// Single-outstanding AXI4 burst initiator (read or write) with stream-side data.
// Optional watchdog compiled in with `define HBM_MASTER_TIMEOUT_EN.
module hbm_axi_burst_master #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic                wr_tvalid,
    input  logic [DATA_W-1:0]   wr_tdata,
    output logic                wr_tready,
    output logic                rd_tvalid,
    output logic [DATA_W-1:0]   rd_tdata,
    output logic                rd_tlast,
    input  logic                rd_tready,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [7:0]          axi_arlen,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic                axi_rlast,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [7:0]          axi_awlen,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic                axi_bvalid,
    output logic                axi_bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic                done_q;
    logic                err_q;
    logic                accept;
    logic                beat;
    logic                fin;
    logic                set_err;
    logic                last_cnt;

    assign last_cnt   = (cnt_q == len_q);
    assign accept     = cmd_valid & (state == IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign axi_araddr = addr_q;
    assign axi_arlen  = len_q;
    assign axi_awaddr = addr_q;
    assign axi_awlen  = len_q;
    assign rd_tdata   = axi_rdata;
    assign axi_wdata  = wr_tdata;
    assign axi_wstrb  = '1;

`ifdef HBM_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            hs;
    logic            wd_exp;

    // Handshakes derived from state and inputs only, avoiding a comb loop.
    assign hs = ((state == AR) & axi_arready)
              | ((state == R)  & axi_rvalid & rd_tready)
              | ((state == AW) & axi_awready)
              | ((state == W)  & wr_tvalid & axi_wready)
              | ((state == B)  & axi_bvalid);
    assign wd_exp = (state != IDLE) & ~hs
                  & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst || state == IDLE || hs) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        axi_arvalid = 1'b0;
        axi_awvalid = 1'b0;
        axi_rready  = 1'b0;
        rd_tvalid   = 1'b0;
        rd_tlast    = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        wr_tready   = 1'b0;
        axi_bready  = 1'b0;
        beat        = 1'b0;
        fin         = 1'b0;
        set_err     = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nx = cmd_write ? AW : AR;
                end
            end
            AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    state_nx = R;
                end
            end
            R: begin
                rd_tvalid  = axi_rvalid;
                axi_rready = rd_tready;
                rd_tlast   = last_cnt | axi_rlast;
                beat       = axi_rvalid & rd_tready;
                if (beat) begin
                    set_err = axi_rlast ^ last_cnt;
                    if (last_cnt | axi_rlast) begin
                        state_nx = IDLE;
                        fin      = 1'b1;
                    end
                end
            end
            AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    state_nx = W;
                end
            end
            W: begin
                axi_wvalid = wr_tvalid;
                wr_tready  = axi_wready;
                axi_wlast  = last_cnt;
                beat       = wr_tvalid & axi_wready;
                if (beat && last_cnt) begin
                    state_nx = B;
                end
            end
            B: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    state_nx = IDLE;
                    fin      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef HBM_MASTER_TIMEOUT_EN
        if (wd_exp) begin
            state_nx = IDLE;
            fin      = 1'b1;
            set_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= fin;
            if (accept) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                if (beat) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (set_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hbm_axi_burst_master.sv
// Randomized bench for hbm_axi_burst_master with a transaction-level slave model.
// Watchdog scenario runs only when HBM_MASTER_TIMEOUT_EN is defined.
module tb_hbm_axi_burst_master;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          ap_rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wr_tvalid, wr_tready;
    logic [DW-1:0] wr_tdata;
    logic          rd_tvalid, rd_tlast, rd_tready;
    logic [DW-1:0] rd_tdata;
    logic          done, err;
    logic [AW-1:0] axi_araddr, axi_awaddr;
    logic [7:0]    axi_arlen, axi_awlen;
    logic          axi_arvalid, axi_arready;
    logic [DW-1:0] axi_rdata, axi_wdata;
    logic          axi_rlast, axi_rvalid, axi_rready;
    logic          axi_awvalid, axi_awready;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wlast, axi_wvalid, axi_wready;
    logic          axi_bvalid, axi_bready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hbm_axi_burst_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .ap_clk(clk), .ap_rst(ap_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_tvalid(wr_tvalid), .wr_tdata(wr_tdata), .wr_tready(wr_tready),
        .rd_tvalid(rd_tvalid), .rd_tdata(rd_tdata), .rd_tlast(rd_tlast),
        .rd_tready(rd_tready), .done(done), .err(err),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        wr_tvalid   = 1'b0;
        rd_tready   = 1'b0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len[7:0];
        #1 check("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 check("err_clr", err, 0);
    endtask

    task automatic finish_chk(input bit fin, input int beats, input int exp_beats,
                              input bit exp_err);
        idle_inputs();
        #1;
        check("no_hang", fin, 1);
        check("beats", beats, exp_beats);
        check("done", done, 1);
        check("idle_rdy", cmd_ready, 1);
        check("err", err, exp_err);
        @(negedge clk);
        #1;
        check("done_pulse", done, 0);
        check("err_sticky", err, exp_err);
    endtask

    // mode: 0 random rd_tready, 1 toggling, 2 always ready
    task automatic do_read(input logic [63:0] addr, input int len,
                           input int last_at, input int mode, input int ar_dly);
        int  beat = 0;
        int  arw  = 0;
        int  cyc  = 0;
        int  term;
        bit  ar_ok = 0;
        bit  fin   = 0;
        term = (last_at < len) ? last_at : len;
        issue(1'b0, addr, len);
        while (!fin && cyc < 3000) begin
            axi_arready = !ar_ok && (arw >= ar_dly);
            axi_rvalid  = ar_ok && ($urandom_range(0, 3) != 0);
            axi_rdata   = addr + 64'(beat);
            axi_rlast   = (beat == last_at);
            case (mode)
                0: rd_tready = 1'($urandom_range(0, 1));
                1: rd_tready = cyc[0] ? 1'b0 : 1'b1;
                default: rd_tready = 1'b1;
            endcase
            #1;
            if (!ar_ok) begin
                check("arvalid", axi_arvalid, 1);
                check("ar_rready", axi_rready, 0);
                if (axi_arready) begin
                    check("araddr", axi_araddr, addr);
                    check("arlen", axi_arlen, 64'(len));
                    ar_ok = 1;
                end
                arw++;
            end else begin
                check("rd_tvalid", rd_tvalid, axi_rvalid);
                check("rready", axi_rready, rd_tready);
                if (axi_rvalid && rd_tready) begin
                    check("rd_tdata", rd_tdata, addr + 64'(beat));
                    check("rd_tlast", rd_tlast, (beat == len) || (beat == last_at));
                    if (beat == term) fin = 1;
                    beat++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        finish_chk(fin, beat, term + 1, last_at != len);
    endtask

    task automatic do_write(input logic [63:0] addr, input int len,
                            input int aw_dly, input int b_dly,
                            input bit hold, input int rst_at);
        int  beat = 0;
        int  wt   = 0;
        int  cyc  = 0;
        int  ph   = 0;
        bit  fin  = 0;
        issue(1'b1, addr, len);
        while (!fin && cyc < 3000) begin
            if (ph == 1 && rst_at >= 0 && beat == rst_at) begin
                ap_rst     = 1'b1;
                wr_tvalid  = 1'b1;
                axi_wready = 1'b1;
                @(negedge clk);
                ap_rst = 1'b0;
                #1;
                check("rst_wvalid", axi_wvalid, 0);
                check("rst_wtready", wr_tready, 0);
                check("rst_awvalid", axi_awvalid, 0);
                check("rst_bready", axi_bready, 0);
                check("rst_cmd_rdy", cmd_ready, 1);
                check("rst_done", done, 0);
                idle_inputs();
                return;
            end
            axi_awready = (ph == 0) && (wt >= aw_dly);
            axi_bvalid  = (ph == 2) && (wt >= b_dly);
            wr_tvalid   = (ph == 1) && (hold || ($urandom_range(0, 3) != 0));
            wr_tdata    = {$urandom, $urandom};
            axi_wready  = (ph == 1) && ($urandom_range(0, 3) != 0);
            #1;
            check("wstrb", axi_wstrb, 8'hff);
            if (ph == 0) begin
                check("awvalid", axi_awvalid, 1);
                check("aw_wvalid", axi_wvalid, 0);
                if (axi_awready) begin
                    check("awaddr", axi_awaddr, addr);
                    check("awlen", axi_awlen, 64'(len));
                    ph = 1;
                end
                wt++;
            end else if (ph == 1) begin
                check("wvalid", axi_wvalid, wr_tvalid);
                check("wr_tready", wr_tready, axi_wready);
                check("wdata", axi_wdata, wr_tdata);
                check("wlast", axi_wlast, beat == len);
                if (wr_tvalid && axi_wready) begin
                    if (beat == len) begin
                        ph = 2;
                        wt = 0;
                    end
                    beat++;
                end
            end else begin
                check("bready", axi_bready, 1);
                check("b_wvalid", axi_wvalid, 0);
                if (axi_bvalid) fin = 1;
                wt++;
            end
            cyc++;
            @(negedge clk);
        end
        finish_chk(fin, beat, len + 1, 1'b0);
    endtask

    initial begin
        idle_inputs();
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_tdata  = '0;
        axi_rdata = '0;
        ap_rst    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        ap_rst = 1'b0;
        #1 check("rst_cmd_ready", cmd_ready, 1);

        do_read(64'h1000, 3, 3, 2, 2);
        do_write(64'h2000, 0, 0, 2, 1'b1, -1);
        do_read(64'h3000, 255, 255, 1, 0);
        do_read(64'h4000, 7, 4, 2, 1);
        do_read(64'h4800, 2, 2, 0, 0);
        do_write(64'h5000, 15, 1, 1, 1'b0, 6);
        do_read(64'h6000, 5, 5, 0, 1);

        for (int i = 0; i < 16; i++) begin
            int len;
            len = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                do_write({$urandom, $urandom}, len, $urandom_range(0, 3),
                         $urandom_range(0, 3), 1'b0, -1);
            end else if (len > 0 && $urandom_range(0, 3) == 0) begin
                do_read({$urandom, $urandom}, len, $urandom_range(0, len - 1),
                        0, $urandom_range(0, 3));
            end else begin
                do_read({$urandom, $urandom}, len, len, 0, $urandom_range(0, 3));
            end
        end

`ifdef HBM_MASTER_TIMEOUT_EN
        begin
            int held = 0;
            issue(1'b0, 64'h7000, 3);
            while (axi_arvalid && held < 100) begin
                held++;
                @(negedge clk);
                #1;
            end
            check("wd_held", held, 16);
            check("wd_done", done, 1);
            check("wd_err", err, 1);
            check("wd_idle", cmd_ready, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hbm_axi_burst_master.md
Name: hbm_axi_burst_master

Overview:
- AXI4 memory-mapped initiator that issues single read or write bursts to an HBM pseudo-channel, or to the HBM emulation model in simulation.
- Accepts one command at a time from CGRA-side control logic.
- Read beats go out on an AXI-Stream-style output; write beats are sourced from an AXI-Stream-style input.
- Exactly one outstanding transaction; a command is not accepted again until the previous one completes.

Parameters:
- ADDR_W, 64, AXI address width (matches dwidth_aximm).
- DATA_W, 512, AXI data width in bits (matches phit_size).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  8  burst length in beats minus 1 (AXI encoding).
- wr_tvalid  in  1  write-data stream valid.
- wr_tdata  in  DATA_W  write-data stream payload.
- wr_tready  out  1  write-data stream ready.
- rd_tvalid  out  1  read-data stream valid.
- rd_tdata  out  DATA_W  read-data stream payload.
- rd_tlast  out  1  marks the final read beat.
- rd_tready  in  1  read-data stream ready.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  sticky error flag; cleared by reset or by the next command accept.
- axi_araddr, axi_arlen, axi_arvalid  out  ADDR_W / 8 / 1  AXI read-address channel.
- axi_arready  in  1  AXI read-address ready.
- axi_rdata, axi_rlast, axi_rvalid  in  DATA_W / 1 / 1  AXI read-data channel.
- axi_rready  out  1  AXI read-data ready.
- axi_awaddr, axi_awlen, axi_awvalid  out  ADDR_W / 8 / 1  AXI write-address channel.
- axi_awready  in  1  AXI write-address ready.
- axi_wdata, axi_wstrb, axi_wlast, axi_wvalid  out  DATA_W / DATA_W/8 / 1 / 1  AXI write-data channel.
- axi_wready  in  1  AXI write-data ready.
- axi_bvalid  in  1  AXI write-response valid.
- axi_bready  out  1  AXI write-response ready.

Behaviour:
- Reset values: all valid outputs, axi_rready, axi_bready, wr_tready, done and err are 0. FSM = IDLE, beat counter = 0. cmd_ready = 1 once in IDLE.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE:
  - Command accepted when cmd_valid & cmd_ready.
  - Latches addr and len, clears count and err.
  - Goes to AW if cmd_write, else AR.
- AR: axi_arvalid = 1 with latched addr/len; address held stable until axi_arready. Go to R on the handshake.
- R (combinational pass-through, zero added latency):
  - rd_tvalid = axi_rvalid; axi_rready = rd_tready; rd_tdata = axi_rdata.
  - A beat transfers on axi_rvalid & rd_tready, and count increments.
  - Terminating beat is the one where count == len or axi_rlast = 1, whichever comes first. rd_tlast = 1 on that beat.
  - If axi_rlast and (count == len) disagree on any beat, set err.
  - After the terminating beat: go to IDLE and pulse done on the next cycle.
- AW: axi_awvalid = 1, held until axi_awready. Go to W on the handshake.
- W (pass-through):
  - axi_wvalid = wr_tvalid; wr_tready = axi_wready; axi_wdata = wr_tdata; axi_wstrb = all ones.
  - axi_wlast = (count == len).
  - A beat transfers on axi_wvalid & axi_wready, and count increments. Go to B after the beat with count == len.
- B: axi_bready = 1. On axi_bvalid, go to IDLE and pulse done on the next cycle.
- Counter width is 8 bits. len = 255 gives 256 beats with no wrap before termination. len = 0 gives a single beat with wlast/rlast asserted on that beat.
- No read beat is dropped: when rd_tready = 0, axi_rready = 0 and the slave stalls.
- Outside R and W, the stream handshakes and AXI data-channel readies/valids are 0.
- A new cmd_valid arriving the same cycle done pulses is not accepted until the FSM is in IDLE; that is the cycle after the terminating event, which is also the done cycle.
- Reset mid-operation: all outputs take their reset values at the next edge and any partial burst is abandoned.

Optional Feature:
- Macro: HBM_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every AXI handshake and on entry into AR/AW.
  - If the FSM stays in AR, R, AW, W or B for TIMEOUT_CYCLES cycles with no handshake, set err, pulse done, and return to IDLE.
- Undefined: no watchdog logic; the FSM waits indefinitely.

Test Plan:
- Read, len=3, slave arready after 2 cycles, rlast on beat 4 -> 4 rd_tvalid beats with data 0..3 in order, rd_tlast on beat 4, done 1 cycle later, err = 0.
- Write, len=0, wr_tvalid held, awready immediate, bvalid 3 cycles after wlast -> exactly 1 W beat with wlast = 1, wstrb = all ones, done the cycle after the B handshake.
- Read, len=255, rd_tready toggling 1/0 each cycle -> 256 beats with no loss or duplication, axi_rready mirrors rd_tready, counter does not wrap early.
- Read, len=7, slave asserts rlast on beat 5 -> transaction ends at beat 5 with rd_tlast, err = 1, done pulses; the next command accept clears err.
- Write, len=15, ap_rst asserted after beat 6 -> all valids 0 at the next edge, FSM in IDLE, cmd_ready = 1; a subsequent read completes normally.
- With HBM_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read where the slave never raises arready -> arvalid held for 16 cycles, then err = 1, done pulses, FSM returns to IDLE.
